// File: rtl/adc_spi_if.sv
// adc_spi_if: groups the signals between the emulated serial ADC and its
// driver side. The driver side is the SPI master pins plus the host sample and
// mode controls.
//   cs, spi_clk      : SPI master chip select (active low) and clock, both asynchronous
//   sdo              : serial data back to the master
//   sample_in/_wr    : host write into the holding register
//   ramp_en          : frame source select (1 = ramp, 0 = holding)
//   busy, frame_done, frame_abort, frame_count : frame status
// Modports: slave = the responder, master = the bench/host side.
interface adc_spi_if #(
  parameter int DATA_BITS = 12
);
  logic                 cs;
  logic                 spi_clk;
  logic                 sdo;
  logic [DATA_BITS-1:0] sample_in;
  logic                 sample_wr;
  logic                 ramp_en;
  logic                 busy;
  logic                 frame_done;
  logic                 frame_abort;
  logic [15:0]          frame_count;

  modport slave (
    input  cs, spi_clk, sample_in, sample_wr, ramp_en,
    output sdo, busy, frame_done, frame_abort, frame_count
  );

  modport master (
    output cs, spi_clk, sample_in, sample_wr, ramp_en,
    input  sdo, busy, frame_done, frame_abort, frame_count
  );
endinterface

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI slave that stands in for the serial ADC.
// It oversamples cs and spi_clk in the clk domain. When cs falls, it shifts out
// LEAD_ZEROS zero bits and then a DATA_BITS sample, MSB first. The next bit is
// presented on each spi_clk fall, because the master samples on the rise.
// The sample is either the host holding register or an internal ramp. The ramp
// advances once per completed frame.
// Ports:
//   clk, reset_b : system clock, synchronous active-low reset
//   bus (slave)  : cs/spi_clk in, sdo out, sample_in/sample_wr/ramp_en in,
//                  busy/frame_done/frame_abort/frame_count out
module adc_spi_responder #(
  parameter int DATA_BITS   = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RAMP_STEP   = 1
) (
  input  logic      clk,
  input  logic      reset_b,
  adc_spi_if.slave  bus
);
  localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;
  localparam int CW         = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sck_prev_q, sck_prev_d;
  logic [FRAME_BITS-1:0]  sh_q, sh_d;
  logic [CW-1:0]          bitcnt_q, bitcnt_d;
  logic                   sdo_q, sdo_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;
  logic [15:0]            fcnt_q, fcnt_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic [DATA_BITS-1:0]   ramp_q, ramp_d;

  logic                   cs_s, sck_s;
  logic                   cs_fall, cs_rise, sck_fall;
  logic [FRAME_BITS-1:0]  word;

  // The synchroniser output is compared with its previous value. That gives
  // edges SYNC_STAGES cycles after the pin change. sdo is registered on top of
  // this, so it moves one cycle later than the edge.
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_fall = sck_prev_q & ~sck_s;

  // Zero-extension supplies the leading zeros. The holding register is read
  // before this cycle's write, so a write on the cs-fall cycle waits for the
  // next frame.
  assign word = FRAME_BITS'(bus.ramp_en ? ramp_q : hold_q);

  always_comb begin
    state_d    = state_q;
    cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], bus.spi_clk};
    cs_prev_d  = cs_s;
    sck_prev_d = sck_s;
    sh_d       = sh_q;
    bitcnt_d   = bitcnt_q;
    sdo_d      = sdo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    fcnt_d     = fcnt_q;
    ramp_d     = ramp_q;
    hold_d     = bus.sample_wr ? bus.sample_in : hold_q;

    case (state_q)
      IDLE: begin
        sdo_d  = 1'b0;
        busy_d = 1'b0;
        if (cs_fall) begin
          state_d  = SHIFT;
          sh_d     = word;
          sdo_d    = word[FRAME_BITS-1];
          bitcnt_d = CW'(1);
          busy_d   = 1'b1;
        end
      end
      SHIFT: begin
        // A cs rise takes priority over an spi_clk fall in the same cycle.
        if (cs_rise) begin
          state_d = IDLE;
          sdo_d   = 1'b0;
          busy_d  = 1'b0;
          abort_d = 1'b1;
        end else if (sck_fall) begin
          if (bitcnt_q < CW'(FRAME_BITS)) begin
            sh_d     = {sh_q[FRAME_BITS-2:0], 1'b0};
            sdo_d    = sh_q[FRAME_BITS-2];
            bitcnt_d = bitcnt_q + CW'(1);
          end else begin
            state_d = TRAIL;
            sdo_d   = 1'b0;
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
            ramp_d  = ramp_q + DATA_BITS'(RAMP_STEP);
          end
        end
      end
      TRAIL: begin
        sdo_d = 1'b0;
        if (cs_rise) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sdo_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      cs_sync_q  <= '1;
      sck_sync_q <= '1;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b1;
      sh_q       <= '0;
      bitcnt_q   <= '0;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      fcnt_q     <= '0;
      hold_q     <= '0;
      ramp_q     <= '0;
    end else begin
      state_q    <= state_d;
      cs_sync_q  <= cs_sync_d;
      sck_sync_q <= sck_sync_d;
      cs_prev_q  <= cs_prev_d;
      sck_prev_q <= sck_prev_d;
      sh_q       <= sh_d;
      bitcnt_q   <= bitcnt_d;
      sdo_q      <= sdo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      fcnt_q     <= fcnt_d;
      hold_q     <= hold_d;
      ramp_q     <= ramp_d;
    end
  end

  assign bus.sdo         = sdo_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_abort = abort_q;
  assign bus.frame_count = fcnt_q;

endmodule
